// File: rtl/onehot_split_32bit_bus.sv
// Sequential bit decomposer: takes one 32-bit word and emits its set bits
// lowest-first, one per beat, as a one-hot word plus bit index.
module onehot_split_32bit_bus (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_onehot,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        out_zero,
    output logic [5:0]  out_total,
    output logic        busy
);

    localparam int unsigned W  = 32;
    localparam int unsigned IW = 5;
    localparam int unsigned CW = 6;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [CW-1:0]  total_q, total_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   low_bit;
    logic [W-1:0]   rem_clr;
    logic [CW-1:0]  pop;
    logic [IW-1:0]  low_idx;
    logic           emit;

    // Popcount of the incoming word, loaded at capture.
    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + CW'(in_word[i]);
        end
    end

    // Lowest set bit of rem, its position, and rem with that bit cleared.
    always_comb begin
        low_bit = rem_q & (~rem_q + W'(1));
        rem_clr = rem_q & (rem_q - W'(1));
        low_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (low_bit[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    assign emit = (state_q == S_EMIT);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        total_d = total_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rem_d   = in_word;
                    total_d = pop;
                    zero_d  = (in_word == '0);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (rem_clr == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_clr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            total_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            total_q <= total_d;
            zero_q  <= zero_d;
        end
    end

    // Beat fields are gated by state so the idle bus reads all zero.
    assign in_ready   = ~emit;
    assign out_valid  = emit;
    assign busy       = emit;
    assign out_onehot = emit ? low_bit : '0;
    assign out_index  = emit ? low_idx : '0;
    assign out_last   = emit && (rem_clr == '0);
    assign out_total  = total_q;
    assign out_zero   = zero_q;

endmodule

// File: doc/onehot_split_32bit_bus.md
# onehot_split_32bit_bus

Sequential bit decomposer for the 32-bit datapath: accepts one 32-bit word and emits its set bits one per beat, lowest bit first, as a one-hot word plus bit index. The bitwise OR of all one-hot beats for a word reproduces that word exactly, which makes this block the inverse of the 32-bit OR combiner. It serves mask-driven sequencing such as register-list walking and interrupt-pending scans. Both sides use a valid/ready handshake.

## Interface
- No parameters; width is fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_word is presented
- in_ready  output  1  block can accept a word
- in_word  input  32  word to decompose
- out_valid  output  1  beat is presented
- out_ready  input  1  consumer accepts the beat
- out_onehot  output  32  single set bit of the current beat; 0 on a zero-word beat
- out_index  output  5  position of the bit in out_onehot; 0 on a zero-word beat
- out_last  output  1  final beat of the current word
- out_zero  output  1  current beat belongs to an all-zero input word
- out_total  output  6  popcount of the current word, 0..32, held for all beats of that word
- busy  output  1  high while in EMIT

## Operation
- State IDLE:
  - in_ready=1, out_valid=0.
  - Input handshake is in_valid && in_ready.
  - On the handshake: capture in_word into internal register rem[31:0], load out_total=popcount(in_word), go to EMIT.
- State EMIT:
  - in_ready=0, out_valid=1.
  - Combinationally, the beat is derived from rem:
    - out_onehot = rem & (~rem + 1), the lowest set bit.
    - out_index = position of that bit.
    - out_last = 1 when rem has at most one set bit.
  - On out_valid && out_ready:
    - If out_last: go to IDLE.
    - Otherwise: rem <= rem & (rem - 1) and stay in EMIT.
  - Without out_ready: rem holds, so every output holds stable. Stalls are unlimited.
- Zero word:
  - Exactly one beat, with out_onehot=0, out_index=0, out_last=1, out_zero=1, out_total=0.
- out_zero:
  - Registered at capture as (in_word==0).
  - Constant for all beats of a word.
- in_word is ignored outside the input handshake.
- Width rules:
  - rem - 1 and ~rem + 1 are modulo 2^32.
  - out_total is 6 bits, so 32 must be representable.
- Reset:
  - Any cycle with rst=1, including mid-EMIT, forces IDLE next cycle.
  - rem=0, out_total=0, out_zero=0; the partial word is discarded and no further beats are emitted.
  - After reset: out_valid=0, in_ready=1, busy=0, out_onehot=0, out_index=0, out_last=0.
  - rst takes priority over any handshake in the same cycle.
- Simultaneous events:
  - No overlap is possible, because in_ready=0 throughout EMIT.
  - A new word is accepted no earlier than the cycle after the last beat's handshake.

## Timing
- Input handshake at edge N: out_valid=1 from cycle N+1.
- Beat j of k (j from 0) is presented at cycle N+1+j, given out_ready held high.
- Last beat handshake at edge M: in_ready=1 in cycle M+1, so there is one bubble between words.
- Throughput is k+1 cycles per word with k set bits, and 2 cycles for a zero word.
- Output timing:
  - out_total and out_zero are registered.
  - out_onehot, out_index and out_last are combinational from rem and state.
  - No combinational path exists from out_ready or in_valid to any output.
- Single-bit special cases:
  - in_word=0x8000_0000 gives one beat: index 31, out_last=1.
  - in_word=0x0000_0001 gives one beat: index 0, out_last=1.

## Test plan
- Reset, then 0x0000_0000 with out_ready=1:
  - One beat: onehot=0, index=0, last=1, zero=1, total=0.
  - in_ready returns to 1 two cycles after the input handshake.
- 0x8000_0011 with out_ready=1:
  - Beats: onehot 0x1/index 0, 0x10/index 4, 0x8000_0000/index 31.
  - last=1 only on the third beat; total=3 on every beat.
  - OR of the beats equals 0x8000_0011.
- 0xFFFF_FFFF with out_ready=1:
  - 32 consecutive beats, indices 0..31; total=32.
  - last asserts on index 31; in_ready stays 0 throughout.
- 0x0000_0A00 with out_ready low for 5 cycles on the first beat:
  - onehot=0x200 and index=9 are held stable for all 5 stall cycles.
  - The next beat is 0x800/index 11 with last=1.
- rst asserted during the 2nd beat of 0x0000_00F0:
  - Next cycle: out_valid=0, in_ready=1, total=0, zero=0, busy=0; no further beats.
  - A new word 0x4 then yields a single beat at index 2.
- Back-to-back: in_valid held high with 0x3 then 0x5, out_ready=1:
  - Beats are index 0, 1 (last), one bubble, then index 0, 2 (last).
  - in_word changes during EMIT have no effect.
